// File: rtl/id_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_entry_pkg
// Purpose  : Shared definitions for the keypad ID-entry block: keypad code
//            constants, the entry FSM state type, the default ID length and a
//            small digit-classification helper.
// Contents : NUM_DIGITS_DEFAULT  default number of BCD digits in an ID
//            KEY_BKSP/ENTER/CANCEL keypad control codes
//            state_t              IDLE / ENTRY / DONE
//            is_digit()           true for codes 0-9
// Revision : 1.0 - initial release
// ============================================================================
package id_entry_pkg;

  localparam int NUM_DIGITS_DEFAULT = 7;

  // Keypad control codes; 4'hD-4'hF are reserved and silently ignored.
  localparam logic [3:0] KEY_BKSP   = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : id_timeout_ctr
// Purpose  : Inactivity counter for the ID-entry FSM. Counts cycles while
//            enabled and not cleared; flags expiry in the cycle where the
//            count is about to reach TIMEOUT_CYCLES-1, so the owner can act
//            on the same edge the count gets there.
// Ports    : clk     in  clock, rising edge
//            rst_n   in  synchronous active-low reset
//            clear   in  restart the count from zero
//            enable  in  count only while high; held at zero otherwise
//            expire  out one-cycle expiry indication (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module id_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // A same-cycle clear (key or start) always beats expiry.
  assign expire = enable && !clear && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/id_entry.sv
`default_nettype none
// ============================================================================
// Module   : id_entry
// Purpose  : Collects a fixed-length BCD ID from a keypad scanner. Digits
//            shift in at the low nibble, backspace shifts the ID back out,
//            enter accepts a complete ID, cancel abandons the entry.
//            Optional inactivity abort is built when ID_ENTRY_TIMEOUT_EN is
//            defined; without it ENTRY waits forever and id_timeout is 0.
// Ports    : iCLK         in  clock, rising edge
//            iRST_N       in  synchronous active-low reset
//            start        in  pulse, begin (or restart) an entry
//            key_valid    in  pulse, key_code valid this cycle
//            key_code     in  0-9 digit, A bksp, B enter, C cancel
//            ID           out packed BCD, most recent digit in [3:0]
//            digit_count  out digits held, 0..NUM_DIGITS
//            busy         out high while collecting digits
//            id_valid     out pulse, ID complete and stable
//            key_err      out pulse, key rejected
//            id_cancel    out pulse, entry cancelled by user
//            id_timeout   out pulse, entry aborted by inactivity
// Revision : 1.0 - initial release
// ============================================================================
module id_entry
  import id_entry_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic                              iCLK,
  input  logic                              iRST_N,
  input  logic                              start,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  output logic [4*NUM_DIGITS-1:0]           ID,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              busy,
  output logic                              id_valid,
  output logic                              key_err,
  output logic                              id_cancel,
  output logic                              id_timeout
);

  localparam int                  IDW   = 4 * NUM_DIGITS;
  localparam int                  CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0]    FULL  = CNT_W'(NUM_DIGITS);

  // Shifting by a nibble needs at least two digits; the counter needs a
  // window of at least two cycles.
  if (NUM_DIGITS < 2) begin : g_bad_num_digits
    $error("id_entry: NUM_DIGITS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("id_entry: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  logic   timeout_hit;
  logic   tmo_clear;
  logic   tmo_enable;

  // Any key, accepted or not, counts as activity, as does a restart.
  assign tmo_clear  = start || key_valid;
  assign tmo_enable = (state == ST_ENTRY);

`ifdef ID_ENTRY_TIMEOUT_EN
  id_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  logic unused_tmo;
  assign unused_tmo = tmo_clear ^ tmo_enable;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= ST_IDLE;
      ID          <= '0;
      digit_count <= '0;
      busy        <= 1'b0;
      id_valid    <= 1'b0;
      key_err     <= 1'b0;
      id_cancel   <= 1'b0;
      id_timeout  <= 1'b0;
    end else begin
      id_valid   <= 1'b0;
      key_err    <= 1'b0;
      id_cancel  <= 1'b0;
      id_timeout <= 1'b0;

      // start has priority in every state; a key arriving with it is dropped
      // without complaint.
      if (start) begin
        state       <= ST_ENTRY;
        ID          <= '0;
        digit_count <= '0;
        busy        <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            // Keys are ignored while idle.
          end

          ST_ENTRY: begin
            if (key_valid) begin
              if (is_digit(key_code)) begin
                if (digit_count != FULL) begin
                  ID          <= {ID[IDW-5:0], key_code};
                  digit_count <= digit_count + CNT_W'(1);
                end else begin
                  key_err <= 1'b1;
                end
              end else begin
                case (key_code)
                  KEY_BKSP: begin
                    if (digit_count != '0) begin
                      ID          <= {4'h0, ID[IDW-1:4]};
                      digit_count <= digit_count - CNT_W'(1);
                    end else begin
                      key_err <= 1'b1;
                    end
                  end
                  KEY_ENTER: begin
                    if (digit_count == FULL) begin
                      state    <= ST_DONE;
                      busy     <= 1'b0;
                      id_valid <= 1'b1;
                    end else begin
                      key_err <= 1'b1;
                    end
                  end
                  KEY_CANCEL: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    ID          <= '0;
                    digit_count <= '0;
                    id_cancel   <= 1'b1;
                  end
                  default: begin
                    // Reserved codes are ignored.
                  end
                endcase
              end
            end else if (timeout_hit) begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              ID          <= '0;
              digit_count <= '0;
              id_timeout  <= 1'b1;
            end
          end

          ST_DONE: begin
            // ID and digit_count hold for the LCD until the next start.
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
